// File: rtl/adder_stream_arbiter_pkg.sv
// rtl/adder_stream_arbiter_pkg.sv - shared widths and FSM encoding for the adder stream arbiter
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 32
`endif
`ifndef DATAW
`define DATAW 32
`endif

package adder_stream_arbiter_pkg;

    // Stream beat width toward the adder and width of the returned sum
    localparam int AXIS_W = `AXIS_MAX_DATAW;
    localparam int RSP_W  = `DATAW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/adder_stream_arbiter_rr_picker.sv
// rtl/adder_stream_arbiter_rr_picker.sv - round-robin pick of the next requester after last_grant
module rr_picker #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [IDW-1:0] grant,
    output logic           any
);

    // Scan from last_grant+1 with wrap; the first set request wins
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!any && req[(int'(last_grant) + off) % N]) begin
                grant = IDW'((int'(last_grant) + off) % N);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_stream_arbiter.sv
// rtl/adder_stream_arbiter.sv - per-packet round-robin arbiter of stream requesters onto one adder
module adder_stream_arbiter
    import adder_stream_arbiter_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int RSP_TIMEOUT = 255,
    localparam int IDW         = $clog2(NUM_REQ),
    localparam int CNTW        = $clog2(RSP_TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_tvalid,
    input  logic [NUM_REQ-1:0]        req_tlast,
    input  logic [NUM_REQ*AXIS_W-1:0] req_tdata,
    output logic [NUM_REQ-1:0]        req_tready,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    output logic [AXIS_W-1:0]         out_tdata,
    input  logic                      out_tready,
    input  logic [RSP_W-1:0]          rsp_in,
    input  logic                      rsp_in_valid,
    output logic [RSP_W-1:0]          rsp_out,
    output logic [NUM_REQ-1:0]        rsp_out_valid,
    output logic                      rsp_err,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
);

    // Last counter value of WAIT_RSP; hitting it means RSP_TIMEOUT cycles elapsed
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RSP_TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [RSP_W-1:0]    rsp_out_q, rsp_out_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;

    rr_picker #(.N(NUM_REQ)) u_rr_picker (
        .req        (req_tvalid),
        .last_grant (last_grant_q),
        .grant      (pick_id),
        .any        (pick_any)
    );

    // State and response registers; last_grant resets to the top index so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            cnt_q        <= '0;
            rsp_out_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_out_q    <= rsp_out_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state logic plus the combinational stream mux toward the adder
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_out_d    = rsp_out_q;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        req_tready   = '0;
        out_tvalid   = 1'b0;
        out_tlast    = 1'b0;
        out_tdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_id;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_tvalid          = req_tvalid[grant_q];
                out_tlast           = req_tlast[grant_q];
                out_tdata           = req_tdata[int'(grant_q)*AXIS_W +: AXIS_W];
                req_tready[grant_q] = out_tready;
                if (out_tvalid && out_tready && out_tlast) begin
                    state_d = ST_WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (rsp_in_valid) begin
                    rsp_out_d            = rsp_in;
                    rsp_valid_d[grant_q] = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_out_d            = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_out       = rsp_out_q;
    assign rsp_out_valid = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// tb/tb_adder_stream_arbiter.sv - directed self-checking bench for adder_stream_arbiter
module tb_adder_stream_arbiter;
    import adder_stream_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int W   = AXIS_W;
    localparam int RW  = RSP_W;
    localparam int TMO = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_tvalid = '0;
    logic [N-1:0]    req_tlast = '0;
    logic [N*W-1:0]  req_tdata = '0;
    logic [N-1:0]    req_tready;
    logic            out_tvalid, out_tlast;
    logic [W-1:0]    out_tdata;
    logic            out_tready = 1'b1;
    logic [RW-1:0]   rsp_in = '0;
    logic            rsp_in_valid = 1'b0;
    logic [RW-1:0]   rsp_out;
    logic [N-1:0]    rsp_out_valid;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            busy;

    int              n_tests = 0;
    int              n_fail = 0;
    int              multi_hot = 0;
    logic [W-1:0]    seen[$];

    adder_stream_arbiter #(.NUM_REQ(N), .RSP_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_tvalid    (req_tvalid),
        .req_tlast     (req_tlast),
        .req_tdata     (req_tdata),
        .req_tready    (req_tready),
        .out_tvalid    (out_tvalid),
        .out_tlast     (out_tlast),
        .out_tdata     (out_tdata),
        .out_tready    (out_tready),
        .rsp_in        (rsp_in),
        .rsp_in_valid  (rsp_in_valid),
        .rsp_out       (rsp_out),
        .rsp_out_valid (rsp_out_valid),
        .rsp_err       (rsp_err),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Log every beat accepted by the adder side
    always @(posedge clk) begin
        if (!rst && out_tvalid && out_tready) seen.push_back(out_tdata);
    end

    // Flag any cycle where more than one requester is ready
    always @(negedge clk) begin
        if ($countones(req_tready) > 1) multi_hot <= multi_hot + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_tvalid = '0;
        req_tlast = '0;
        req_tdata = '0;
        rsp_in_valid = 1'b0;
        out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offer one beat from requester id and wait until the adder takes it
    task automatic beat(input int id, input logic [W-1:0] d, input logic last);
        int k;
        k = 0;
        req_tvalid[id] = 1'b1;
        req_tlast[id] = last;
        req_tdata[id*W +: W] = d;
        #1;
        while (!(req_tready[id] && out_tvalid) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            check("beat_wait", 64'd0, 64'd1);
        end else begin
            check("beat_data", out_tdata, d);
            check("beat_grant", grant_id, id);
        end
        @(posedge clk);
        #1;
        req_tvalid[id] = 1'b0;
        req_tlast[id] = 1'b0;
    endtask

    task automatic respond(input logic [RW-1:0] val);
        rsp_in = val;
        rsp_in_valid = 1'b1;
        @(posedge clk);
        #1;
        rsp_in_valid = 1'b0;
    endtask

    // Check the response pulse now, then that it drops while the data holds
    task automatic check_rsp(input int id, input logic [RW-1:0] val, input logic err);
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        check("rsp_valid", rsp_out_valid, oh);
        check("rsp_data", rsp_out, val);
        check("rsp_err", rsp_err, err);
        @(posedge clk);
        #1;
        check("rsp_pulse_end", {rsp_out_valid, rsp_err}, 0);
        check("rsp_hold", rsp_out, val);
    endtask

    initial begin
        int cnt_w;
        int guard;
        logic [N-1:0] order [5];

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_tready", req_tready, 0);
        check("rst_out", {out_tvalid, out_tlast, out_tdata}, 0);
        check("rst_rsp", {rsp_out, rsp_out_valid, rsp_err}, 0);

        // A response outside WAIT_RSP is dropped
        respond(32'd99);
        check("stray_rsp_valid", rsp_out_valid, 0);
        check("stray_rsp_data", rsp_out, 0);

        // Single requester packet 3,5,7 summed to 15
        req_tvalid[0] = 1'b1;
        req_tdata[W-1:0] = 32'd3;
        #1;
        check("idle_no_fwd", out_tvalid, 0);
        beat(0, 32'd3, 1'b0);
        beat(0, 32'd5, 1'b0);
        beat(0, 32'd7, 1'b1);
        check("wait_busy", busy, 1);
        check("wait_quiet", {out_tvalid, req_tready}, 0);
        respond(32'd15);
        check_rsp(0, 32'd15, 1'b0);

        // Requesters 0 and 2 together: 0 first, 2's data never leaks
        do_reset();
        req_tvalid[2] = 1'b1;
        req_tlast[2] = 1'b1;
        req_tdata[2*W +: W] = 32'h20;
        beat(0, 32'h10, 1'b0);
        beat(0, 32'h11, 1'b1);
        respond(32'h21);
        check_rsp(0, 32'h21, 1'b0);
        beat(2, 32'h20, 1'b1);
        respond(32'h40);
        check_rsp(2, 32'h40, 1'b0);

        // All four requesting one-beat packets: order 0,1,2,3,0
        do_reset();
        order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        for (int r = 0; r < N; r++) begin
            req_tdata[r*W +: W] = 32'h100 + r;
        end
        req_tvalid = '1;
        req_tlast = '1;
        for (int p = 0; p < 5; p++) begin
            guard = 0;
            while (!out_tvalid && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("rr_grant", grant_id, order[p]);
            check("rr_data", out_tdata, 32'h100 + order[p]);
            @(posedge clk);
            #1;
            respond(32'h500 + p);
            check_rsp(int'(order[p]), 32'h500 + p, 1'b0);
        end
        req_tvalid = '0;
        req_tlast = '0;

        // Backpressure for 10 cycles, then a tvalid gap, on requester 1
        do_reset();
        seen.delete();
        beat(1, 32'hA1, 1'b0);
        req_tvalid[1] = 1'b1;
        req_tdata[W +: W] = 32'hA2;
        out_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_tready", req_tready, 0);
        end
        out_tready = 1'b1;
        req_tvalid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("gap_hold", {busy, grant_id, out_tvalid}, {1'b1, 2'd1, 1'b0});
        beat(1, 32'hA2, 1'b0);
        beat(1, 32'hA3, 1'b1);
        check("stall_count", seen.size(), 3);
        if (seen.size() == 3) begin
            check("stall_b0", seen[0], 32'hA1);
            check("stall_b1", seen[1], 32'hA2);
            check("stall_b2", seen[2], 32'hA3);
        end
        respond(32'h777);
        check_rsp(1, 32'h777, 1'b0);

        // No response: error pulse after RSP_TIMEOUT cycles in WAIT_RSP
        beat(3, 32'h33, 1'b1);
        cnt_w = 0;
        guard = 0;
        while (rsp_out_valid == 0 && guard < 400) begin
            if (busy) cnt_w++;
            @(posedge clk);
            #1;
            guard++;
        end
        check("tmo_cycles", cnt_w, TMO);
        check_rsp(3, 32'd0, 1'b1);

        // Response on the timeout cycle wins over the error
        beat(0, 32'h44, 1'b1);
        repeat (TMO - 1) @(posedge clk);
        #1;
        respond(32'h55);
        check_rsp(0, 32'h55, 1'b0);

        // Reset while waiting for the sum
        beat(2, 32'h22, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstw_state", {busy, grant_id, req_tready}, 0);
        check("rstw_out", {out_tvalid, out_tlast, out_tdata}, 0);
        check("rstw_rsp", {rsp_out, rsp_out_valid, rsp_err}, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rstw_no_pulse", {rsp_out_valid, rsp_err}, 0);
        end
        req_tvalid[1] = 1'b1;
        req_tlast[1] = 1'b1;
        req_tdata[W +: W] = 32'h61;
        beat(0, 32'h60, 1'b1);

        check("multi_hot", multi_hot, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
